// File: rtl/data_storer.sv
// data_storer: drains a fixed region of one core's data memory to external
// memory. Each line is 16 words read from data memory, packed into 512 bits
// and sent as one single-beat Avalon-MM write.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   kick, busy          start request (taken in IDLE); busy = busy_reg | kick
//   memory_base_addr    external byte address of line 0 (latched on kick)
//   target_core         core whose data memory is drained (latched on kick)
//   data_addr, data_din data-memory read port; read data lags address by 1
//   m0_*                Avalon-MM master (writes only, burst of 1)
module data_storer #(
   parameter int CORES       = 4,
   parameter int DMEM_DEPTH  = 14,
   parameter int STORE_BYTES = 8192
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 kick,
   output logic                                 busy,
   input  logic [63:0]                          memory_base_addr,
   input  logic [$clog2(CORES)-1:0]             target_core,
   output logic [$clog2(CORES)+DMEM_DEPTH+1:0]  data_addr,
   input  logic [31:0]                          data_din,
   input  logic                                 m0_waitrequest,
   input  logic [511:0]                         m0_readdata,
   input  logic                                 m0_readdatavalid,
   output logic [2:0]                           m0_burstcount,
   output logic [511:0]                         m0_writedata,
   output logic [63:0]                          m0_address,
   output logic                                 m0_write,
   output logic                                 m0_read,
   output logic [63:0]                          m0_byteenable,
   output logic                                 m0_debugaccess
);

   localparam int CW     = $clog2(CORES);
   localparam int LINES  = STORE_BYTES / 64;
   localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

   state_t               state_q, state_d;
   logic                 busy_q, busy_d;
   logic [LINE_W-1:0]    line_q, line_d;
   logic [4:0]           fill_q, fill_d;
   logic [63:0]          base_q, base_d;
   logic [CW-1:0]        core_q, core_d;
   logic [14:0][31:0]    buf_q, buf_d;
   logic                 wr_q, wr_d;
   logic [63:0]          addr_q, addr_d;
   logic [511:0]         wdata_q, wdata_d;

   logic [DMEM_DEPTH-1:0] word_idx;
   logic [3:0]            slot;
   logic                  unused_inputs;

   assign unused_inputs = ^{m0_readdata, m0_readdatavalid};

   // Word index line*16 + fill; wraps to the data-memory depth.
   assign word_idx = DMEM_DEPTH'({line_q, fill_q[3:0]});
   // Read issued at fill=k returns at fill=k+1, so it lands in slot fill-1.
   assign slot     = 4'(fill_q - 5'd1);

   assign data_addr = (state_q == S_FILL && !fill_q[4]) ? {core_q, word_idx, 2'b00} : '0;

   assign busy           = busy_q | kick;
   assign m0_write       = wr_q;
   assign m0_address     = addr_q;
   assign m0_writedata   = wdata_q;
   assign m0_burstcount  = 3'd1;
   assign m0_read        = 1'b0;
   assign m0_byteenable  = '1;
   assign m0_debugaccess = 1'b0;

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      line_d  = line_q;
      fill_d  = fill_q;
      base_d  = base_q;
      core_d  = core_q;
      buf_d   = buf_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (kick) begin
               base_d  = memory_base_addr;
               core_d  = target_core;
               line_d  = '0;
               fill_d  = '0;
               busy_d  = 1'b1;
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            fill_d = fill_q + 5'd1;
            if (fill_q == 5'd16) begin
               // Slot 15 comes straight from the read port; no extra cycle.
               wdata_d = {data_din, buf_q};
               addr_d  = base_q + 64'({line_q, 6'b0});
               wr_d    = 1'b1;
               state_d = S_WRITE;
            end else if (fill_q != 5'd0) begin
               buf_d[slot] = data_din;
            end
         end
         S_WRITE: begin
            if (!m0_waitrequest) begin
               wr_d = 1'b0;
               if (line_q == LAST_LINE) begin
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  line_d  = line_q + 1'b1;
                  fill_d  = '0;
                  state_d = S_FILL;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         line_q  <= '0;
         fill_q  <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         line_q  <= line_d;
         fill_q  <= fill_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Latched transfer parameters and line buffer carry no reset.
   always_ff @(posedge clk) begin
      base_q <= base_d;
      core_q <= core_d;
      buf_q  <= buf_d;
   end

endmodule

// File: tb/tb_data_storer.sv
module tb_data_storer;

   localparam int LINES = 128;

   logic         clk = 1'b0;
   logic         reset;
   logic         kick;
   logic         busy;
   logic [63:0]  memory_base_addr;
   logic [1:0]   target_core;
   logic [17:0]  data_addr;
   logic [31:0]  data_din;
   logic         m0_waitrequest;
   logic [511:0] m0_readdata;
   logic         m0_readdatavalid;
   logic [2:0]   m0_burstcount;
   logic [511:0] m0_writedata;
   logic [63:0]  m0_address;
   logic         m0_write;
   logic         m0_read;
   logic [63:0]  m0_byteenable;
   logic         m0_debugaccess;

   data_storer #(.CORES(4), .DMEM_DEPTH(14), .STORE_BYTES(8192)) dut (
      .clk(clk), .reset(reset), .kick(kick), .busy(busy),
      .memory_base_addr(memory_base_addr), .target_core(target_core),
      .data_addr(data_addr), .data_din(data_din),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid), .m0_burstcount(m0_burstcount),
      .m0_writedata(m0_writedata), .m0_address(m0_address), .m0_write(m0_write),
      .m0_read(m0_read), .m0_byteenable(m0_byteenable), .m0_debugaccess(m0_debugaccess)
   );

   always #5 clk = ~clk;

   // Data memories of all cores; read data one cycle after the address.
   logic [31:0] dmem [4][16384];
   always @(posedge clk) data_din <= dmem[data_addr[17:16]][data_addr[15:2]];

   int checks = 0;
   int errors = 0;

   // Reference transfer state
   bit          active = 1'b0;
   int          cyc = -1;
   int          acc = 0;
   int          fill_pos = 0;
   logic [63:0] base_m;
   int          core_m;
   int          stall_line = -1;
   int          stall_left = 0;
   int          first_acc_edge = 0;
   int          last_acc_edge = 0;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [63:0] exp_addr(input int n);
      return base_m + 64'(n) * 64'd64;
   endfunction

   function automatic logic [511:0] exp_data(input int n);
      logic [511:0] d;
      for (int k = 0; k < 16; k++) d[32*k +: 32] = dmem[core_m][(16*n + k) % 16384];
      return d;
   endfunction

   function automatic logic [17:0] exp_daddr(input int n, input int k);
      int w;
      w = (16*n + k) % 16384;
      return {2'(core_m), 16'(w * 4)};
   endfunction

   always @(posedge clk) if (active) cyc++;

   // Avalon slave + read-sequence monitor
   always @(negedge clk) begin
      if (active && cyc >= 0) begin
         if (m0_write && acc == stall_line && stall_left > 0) begin
            m0_waitrequest = 1'b1;
            stall_left--;
         end else begin
            m0_waitrequest = 1'b0;
         end
         if (m0_write) begin
            check("line_addr", 512'(m0_address), 512'(exp_addr(acc)));
            check("line_data", m0_writedata, exp_data(acc));
            check("fill_len", 512'(fill_pos), 512'(17));
            if (acc + 1 < LINES)
               check("early_read", 512'(data_addr == exp_daddr(acc + 1, 0)), 512'(0));
            if (!m0_waitrequest) begin
               acc++;
               if (acc == 1) first_acc_edge = cyc + 1;
               last_acc_edge = cyc + 1;
               fill_pos = 0;
            end
         end else if (acc < LINES) begin
            if (fill_pos < 16)
               check("rd_addr", 512'(data_addr), 512'(exp_daddr(acc, fill_pos)));
            fill_pos++;
            check("write_late", 512'(fill_pos <= 17), 512'(1));
         end
      end
   end

   task automatic start_kick(input int core, input logic [63:0] base, input int sl, input int sn);
      @(negedge clk);
      kick = 1'b1;
      target_core = 2'(core);
      memory_base_addr = base;
      base_m = base;
      core_m = core;
      acc = 0;
      fill_pos = 0;
      cyc = -1;
      stall_line = sl;
      stall_left = sn;
      first_acc_edge = 0;
      last_acc_edge = 0;
      active = 1'b1;
      #1 check("busy_kick", 512'(busy), 512'(1));
      @(negedge clk);
      kick = 1'b0;
      target_core = 2'($urandom);
      memory_base_addr = {$urandom, $urandom};
   endtask

   task automatic run_transfer(input int core, input logic [63:0] base, input int sl,
                               input int sn, input bit midkick);
      start_kick(core, base, sl, sn);
      if (midkick) begin
         repeat (300) @(negedge clk);
         kick = 1'b1;
         target_core = 2'(core + 1);
         memory_base_addr = base ^ 64'h5555_0000;
         @(negedge clk);
         kick = 1'b0;
      end
      for (int i = 0; i < 4000 && acc < LINES; i++) @(negedge clk);
      check("line_count", 512'(acc), 512'(LINES));
      check("first_accept", 512'(first_acc_edge), 512'(18));
      check("xfer_cycles", 512'(last_acc_edge), 512'(2304 + sn));
      for (int i = 0; i < 10 && cyc < last_acc_edge; i++) @(negedge clk);
      #1;
      check("busy_done", 512'(busy), 512'(0));
      check("write_done", 512'(m0_write), 512'(0));
      active = 1'b0;
      m0_waitrequest = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      kick = 1'b0;
      memory_base_addr = '0;
      target_core = '0;
      m0_waitrequest = 1'b0;
      m0_readdata = '0;
      m0_readdatavalid = 1'b0;
      for (int c = 0; c < 4; c++)
         for (int i = 0; i < 16384; i++)
            dmem[c][i] = (c == 2) ? 32'hA500_0000 + 32'(i) : $urandom;

      // Reset with random inputs
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         reset = 1'b0;
         kick = 1'($urandom);
         memory_base_addr = {$urandom, $urandom};
         target_core = 2'($urandom);
         m0_waitrequest = 1'($urandom);
         @(posedge clk);
         #1;
         check("rst_write", 512'(m0_write), 512'(0));
         check("rst_addr", 512'(m0_address), 512'(0));
         check("rst_wdata", m0_writedata, 512'(0));
         check("rst_daddr", 512'(data_addr), 512'(0));
         check("rst_burst", 512'(m0_burstcount), 512'(1));
         check("rst_be", 512'(m0_byteenable), 512'(64'hFFFF_FFFF_FFFF_FFFF));
         check("rst_read", 512'(m0_read), 512'(0));
         check("rst_dbg", 512'(m0_debugaccess), 512'(0));
         check("rst_busy", 512'(busy), 512'(kick));
      end
      @(negedge clk);
      kick = 1'b0;
      m0_waitrequest = 1'b0;
      reset = 1'b1;
      @(negedge clk);

      // Basic store from core 2
      run_transfer(2, 64'h1000_0000, -1, 0, 1'b0);
      // Stall on line 3 from core 1
      run_transfer(1, {$urandom, $urandom}, 3, 5, 1'b0);
      // Core 3, address wrap, ignored kick mid-transfer
      run_transfer(3, 64'hFFFF_FFFF_FFFF_F000, -1, 0, 1'b1);

      // Reset while a write is stalled
      start_kick(0, 64'h4000_0000, 5, 1000);
      for (int i = 0; i < 4000 && !(acc == 5 && m0_write); i++) @(negedge clk);
      check("abort_reached", 512'(acc == 5 && m0_write), 512'(1));
      @(negedge clk);
      active = 1'b0;
      reset = 1'b0;
      m0_waitrequest = 1'b1;
      @(posedge clk);
      #1;
      check("abort_write", 512'(m0_write), 512'(0));
      check("abort_busy", 512'(busy), 512'(0));
      check("abort_daddr", 512'(data_addr), 512'(0));
      @(negedge clk);
      reset = 1'b1;
      m0_waitrequest = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_abort", 512'(m0_write), 512'(0));
      run_transfer(2, 64'h2000_0000, -1, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
